arb3_rr: RTL and testbench
==========================

Name: arb3_rr

Overview:
- Round-robin arbiter that shares one 3-input datapath resource among three requesters.
- Drives the 2-bit select of the team's 3-way datapath mux: 00 = d0, 01 = d1, 10 = d2, 11 = no source (mux outputs zero).
- Grants are held for a whole transaction, with an optional hold limit that forces rotation when other requesters are waiting.
- Sits beside the shared-bus mux in the lab datapath; requesters are the three producing stages.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one owner may hold while another requester waits; 0 = unlimited.
- CNT_W, 16, width of the per-requester grant counters (used only with the optional feature).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- req, input, 3, level request per requester; held high for the whole transaction.
- grant, output, 3, one-hot registered grant; all-zero when idle.
- sel, output, 2, registered mux select encoded from grant: 00/01/10; 11 when idle.
- busy, output, 1, high while any grant is active.
- hold_cnt, output, $clog2(MAX_HOLD+1) (min 1), cycles the current owner has held; 0 when idle.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered; nothing is asynchronous.
- Reset (sampled high at an edge):
  - grant=000, sel=11, busy=0, hold_cnt=0.
  - state=IDLE, priority pointer ptr=0 (req[0] highest priority).
  - Reset mid-transaction drops the grant at that same edge.
- States: IDLE, OWN.
- IDLE:
  - No req at the edge: stay IDLE.
  - Otherwise grant the first set req scanning ptr, ptr+1, ptr+2 (mod 3) and go to OWN with hold_cnt=1.
  - Latency is 1 edge: req high before edge N means grant is visible after edge N.
- OWN, owner index o:
  - req[o]=1 and no forced rotation: keep the grant; hold_cnt increments, saturating at MAX_HOLD.
  - req[o]=0 (release): re-arbitrate at the same edge with no bubble.
    - Scan from (o+1) mod 3, excluding o.
    - If another req is set, grant it with hold_cnt=1; otherwise go to IDLE (grant=000, sel=11, hold_cnt=0).
  - Forced rotation: MAX_HOLD>0, hold_cnt==MAX_HOLD, req[o]=1 and some other req set.
    - Grant the next requester from (o+1) mod 3 at that edge.
    - The former owner's still-high req competes again normally.
    - If no other req is set, the owner keeps the grant and hold_cnt holds at MAX_HOLD.
- Pointer: ptr is set to (g+1) mod 3 whenever a new grant to index g is issued. This gives fairness: each waiting requester is served within 2 transactions.
- Invariants:
  - grant is always one-hot or zero.
  - sel always equals the encoding of grant.
  - busy == |grant.
  - Grant never switches between owners without passing through a single edge; a handover is exactly 1 edge.
- Simultaneous events: release plus new requests at the same edge goes directly to the next owner. A requester that raises and drops req between edges is never seen.

Optional Feature:
- Macro: ARB3_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1, grant_cnt2 (CNT_W bits each).
  - Each counts new grant events for its requester (not cycles held), saturates at all-ones, and clears on reset.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package arb_pkg:
  - typedef sel_t (logic [1:0]).
  - Constants SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10, SEL_NONE=2'b11.
  - typedef enum arb_state_t {IDLE, OWN}.
  - Function onehot_to_sel.
- One sub-module, rr_pick3: purely combinational.
  - Inputs: req (3), start index (2), exclude mask (3).
  - Outputs: found (1), index (2).
  - Used for both the IDLE scan and the handover scan.

Test Plan:
1. Reset then idle: reset=1 for 2 edges with req=111 → grant=000, sel=11, busy=0. After release, the first edge gives grant=001, sel=00, hold_cnt=1.
2. Round-robin handover: req=111 held; each owner drops its req for 1 cycle after 3 cycles → grant sequence 001→010→100→001, with a 1-edge handover and no idle cycle.
3. Single requester: only req[1] high for 20 cycles (MAX_HOLD=8) → grant=010 throughout and hold_cnt saturates at 8. Drop req → IDLE, sel=11 next edge.
4. Forced rotation: req[0] held, req[2] raised at cycle 3 (MAX_HOLD=8) → grant moves to 100 on the edge where hold_cnt==8. req[0] regains the grant after req[2] releases.
5. Reset mid-transaction: owner=2 with hold_cnt=5, reset pulse → grant=000, sel=11, ptr=0 at that edge. Next grant with req=110 goes to index 1.
6. ARB3_STATS_EN: 5 grants to req0 and 3 to req2 → grant_cnt0=5, grant_cnt1=0, grant_cnt2=3. With CNT_W=2, 5 grants saturate at 3.

Source files
------------

// File: rtl/arb3_rr_pkg.sv
// Shared types and helpers for the 3-way round-robin arbiter and its mux select.
package arb_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0   = 2'b00;
    localparam sel_t SEL_D1   = 2'b01;
    localparam sel_t SEL_D2   = 2'b10;
    localparam sel_t SEL_NONE = 2'b11;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

    // hold_cnt needs at least one bit even when the hold limit is disabled
    function automatic int hold_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

    function automatic logic [1:0] inc_mod3(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic sel_t onehot_to_sel(input logic [2:0] g);
        case (g)
            3'b001:  return SEL_D0;
            3'b010:  return SEL_D1;
            3'b100:  return SEL_D2;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arb3_rr_if.sv
// Request/grant bundle between the three producers and arb3_rr.
// Optional per-requester grant counters appear when ARB3_STATS_EN is defined.
interface arb3_rr_if #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
);
    import arb_pkg::*;

    localparam int HOLD_W = hold_width(MAX_HOLD);

    logic [2:0]        req;
    logic [2:0]        grant;
    sel_t              sel;
    logic              busy;
    logic [HOLD_W-1:0] hold_cnt;

`ifdef ARB3_STATS_EN
    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;
    logic [CNT_W-1:0]  grant_cnt2;

    modport master (output req, input grant, sel, busy, hold_cnt,
                    input grant_cnt0, grant_cnt1, grant_cnt2);
    modport slave  (input req, output grant, sel, busy, hold_cnt,
                    output grant_cnt0, grant_cnt1, grant_cnt2);
`else
    modport master (output req, input grant, sel, busy, hold_cnt);
    modport slave  (input req, output grant, sel, busy, hold_cnt);
`endif

endinterface

// File: rtl/arb3_rr_pick3.sv
// Combinational rotating picker: first set, non-excluded request scanning
// start, start+1, start+2 (mod 3). A start of 3 is treated as 0.
module rr_pick3
    import arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] start,
    input  logic [2:0] exclude,
    output logic       found,
    output logic [1:0] index
);

    logic [2:0] cand;
    logic [1:0] idx;

    // NOTE: every output and temporary gets a default first so no path leaves
    // a value unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        index = 2'd0;
        cand  = req & ~exclude;
        idx   = (start == 2'd3) ? 2'd0 : start;
        for (int k = 0; k < 3; k++) begin
            if (!found && |(cand & (3'b001 << idx))) begin
                found = 1'b1;
                index = idx;
            end
            idx = inc_mod3(idx);
        end
    end

endmodule

// File: rtl/arb3_rr.sv
// Round-robin arbiter for the shared 3-input datapath mux, with a hold limit
// that forces rotation. Optional grant statistics under ARB3_STATS_EN.
module arb3_rr
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic      clk,
    input  logic      reset,
    arb3_rr_if.slave  bus
);

    localparam int HOLD_W = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};

    arb_state_t        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [1:0]        ptr_q,   ptr_d;
    sel_t              sel_q;
    logic              busy_q;
    logic              new_grant;

    logic [1:0] pick_start;
    logic [2:0] pick_excl;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       rotate;

    // While owning, sel_q is the owner index, so the handover scan starts after it
    assign pick_start = (state_q == OWN) ? inc_mod3(sel_q) : ptr_q;
    assign pick_excl  = (state_q == OWN) ? grant_q : 3'b000;

    rr_pick3 u_pick (
        .req     (bus.req),
        .start   (pick_start),
        .exclude (pick_excl),
        .found   (pick_found),
        .index   (pick_idx)
    );

    assign owner_req = |(bus.req & grant_q);
    assign rotate    = (MAX_HOLD > 0) && (hold_q == HOLD_SAT) && pick_found;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;

        if (state_q == OWN && owner_req && !rotate) begin
            if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
        end else if (pick_found) begin
            state_d   = OWN;
            grant_d   = 3'b001 << pick_idx;
            hold_d    = HOLD_W'(1);
            ptr_d     = inc_mod3(pick_idx);
            new_grant = 1'b1;
        end else begin
            state_d = IDLE;
            grant_d = 3'b000;
            hold_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            hold_q  <= '0;
            ptr_q   <= 2'd0;
            sel_q   <= SEL_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            sel_q   <= onehot_to_sel(grant_d);
            busy_q  <= |grant_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.hold_cnt = hold_q;

`ifdef ARB3_STATS_EN
    logic [CNT_W-1:0] cnt_q [3];

    // Counts grant events, not cycles held; each counter sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (new_grant) begin
            for (int i = 0; i < 3; i++) begin
                if (pick_idx == 2'(i) && cnt_q[i] != {CNT_W{1'b1}})
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign bus.grant_cnt0 = cnt_q[0];
    assign bus.grant_cnt1 = cnt_q[1];
    assign bus.grant_cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_arb3_rr.sv
// Self-checking bench for arb3_rr: directed vector table, hand sequences for
// hold saturation / forced rotation / mid-transaction reset, then random traffic.
module tb_arb3_rr;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arb3_rr_if #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) bus ();

    arb3_rr #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 idle), cycles held, rotation pointer
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;
    int m_cnt [3] = '{0, 0, 0};
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input int g);
        case (g)
            1: return 0;
            2: return 1;
            4: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check_out(input string name, input int g, input int h);
        check({name, ".grant"}, int'(bus.grant), g);
        check({name, ".sel"}, int'(bus.sel), sel_of(g));
        check({name, ".busy"}, int'(bus.busy), (g != 0) ? 1 : 0);
        check({name, ".hold"}, int'(bus.hold_cnt), h);
    endtask

    function automatic void model_grant(input int idx);
        m_owner = idx;
        m_hold  = 1;
        m_ptr   = (idx + 1) % 3;
        if (m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
    endfunction

    function automatic void model_edge(input logic r, input logic [2:0] q);
        bit done;
        if (r) begin
            m_owner = -1; m_hold = 0; m_ptr = 0;
            m_cnt = '{0, 0, 0};
            return;
        end
        done = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < 3; k++)
                if (!done && q[(m_ptr + k) % 3]) begin
                    model_grant((m_ptr + k) % 3);
                    done = 1;
                end
        end else begin
            bit others = 0;
            for (int k = 1; k < 3; k++) if (q[(m_owner + k) % 3]) others = 1;
            if (q[m_owner] && !(m_hold == MAX_HOLD && others)) begin
                if (m_hold < MAX_HOLD) m_hold++;
            end else begin
                int from = m_owner;
                for (int k = 1; k < 3; k++)
                    if (!done && q[(from + k) % 3]) begin
                        model_grant((from + k) % 3);
                        done = 1;
                    end
                if (!done) begin
                    m_owner = -1; m_hold = 0;
                end
            end
        end
    endfunction

    task automatic step(input logic r, input logic [2:0] q);
        reset   = r;
        bus.req = q;
        model_edge(r, q);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] req;
        int         grant;
        int         hold;
    } vec_t;

    vec_t vecs [16];

    initial begin
        reset   = 1'b1;
        bus.req = 3'b000;

        // Reset, idle and round-robin handover with no bubble
        vecs[0]  = '{1'b1, 3'b111, 0, 0};
        vecs[1]  = '{1'b1, 3'b111, 0, 0};
        vecs[2]  = '{1'b0, 3'b111, 1, 1};
        vecs[3]  = '{1'b0, 3'b111, 1, 2};
        vecs[4]  = '{1'b0, 3'b111, 1, 3};
        vecs[5]  = '{1'b0, 3'b110, 2, 1};
        vecs[6]  = '{1'b0, 3'b111, 2, 2};
        vecs[7]  = '{1'b0, 3'b111, 2, 3};
        vecs[8]  = '{1'b0, 3'b101, 4, 1};
        vecs[9]  = '{1'b0, 3'b111, 4, 2};
        vecs[10] = '{1'b0, 3'b111, 4, 3};
        vecs[11] = '{1'b0, 3'b011, 1, 1};
        vecs[12] = '{1'b0, 3'b000, 0, 0};
        vecs[13] = '{1'b0, 3'b010, 2, 1};
        vecs[14] = '{1'b0, 3'b000, 0, 0};
        vecs[15] = '{1'b0, 3'b101, 4, 1};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].req);
            check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].hold);
        end

        // Single requester: hold saturates at MAX_HOLD, then release to idle
        step(1'b1, 3'b000);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 3'b010);
            check_out($sformatf("single%0d", k), 2, (k < MAX_HOLD) ? k : MAX_HOLD);
        end
        step(1'b0, 3'b000);
        check_out("single_release", 0, 0);

        // Forced rotation: req0 held, req2 joins at cycle 3
        step(1'b1, 3'b000);
        for (int k = 1; k <= MAX_HOLD; k++) begin
            step(1'b0, (k >= 3) ? 3'b101 : 3'b001);
            check_out($sformatf("rot%0d", k), 1, k);
        end
        step(1'b0, 3'b101);
        check_out("rot_switch", 4, 1);
        step(1'b0, 3'b101);
        check_out("rot_hold2", 4, 2);
        step(1'b0, 3'b001);
        check_out("rot_back", 1, 1);

        // Reset mid-transaction drops grant at that edge and clears ptr
        step(1'b1, 3'b000);
        for (int k = 1; k <= 5; k++) step(1'b0, 3'b100);
        check_out("mid_pre", 4, 5);
        step(1'b1, 3'b100);
        check_out("mid_reset", 0, 0);
        step(1'b0, 3'b110);
        check_out("mid_after", 2, 1);
        step(1'b0, 3'b000);
        step(1'b0, 3'b001);
        step(1'b1, 3'b001);
        check_out("mid_reset2", 0, 0);
        step(1'b0, 3'b101);
        check_out("ptr_cleared", 1, 1);

`ifdef ARB3_STATS_EN
        step(1'b1, 3'b000);
        for (int k = 0; k < 5; k++) begin step(1'b0, 3'b001); step(1'b0, 3'b000); end
        for (int k = 0; k < 3; k++) begin step(1'b0, 3'b100); step(1'b0, 3'b000); end
        check("stats_cnt0", int'(bus.grant_cnt0), 5);
        check("stats_cnt1", int'(bus.grant_cnt1), 0);
        check("stats_cnt2", int'(bus.grant_cnt2), 3);
`endif

        // Random traffic against the reference model
        step(1'b1, 3'b000);
        begin
            logic [2:0] q = 3'b000;
            for (int n = 0; n < 3000; n++) begin
                logic r;
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(3) == 0) q[b] = ~q[b];
                r = ($urandom_range(99) == 0);
                step(r, q);
                check_out($sformatf("rand%0d", n),
                          (m_owner < 0) ? 0 : (1 << m_owner), m_hold);
`ifdef ARB3_STATS_EN
                if (n % 100 == 99) begin
                    check("rand_cnt0", int'(bus.grant_cnt0), m_cnt[0]);
                    check("rand_cnt1", int'(bus.grant_cnt1), m_cnt[1]);
                    check("rand_cnt2", int'(bus.grant_cnt2), m_cnt[2]);
                end
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
